mem_arbiter: RTL and testbench

// - Shares the single-ported data memory between IFU (read-only fetch) and LSU (load/store).
// - Accepts one request at a time over valid/ready, sequences one memory access, returns data to the owner.
// - Round-robin arbitration between the two requesters; one outstanding transaction total.
// - Sits between the IFU/LSU stages and the data memory block.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_rr_arb2.sv | 17 +
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states and owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Owner value doubles as the bit index into the two-bit valid/grant vectors.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone valid wins, a tie goes to the side not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported data memory between IFU fetches and LSU loads/stores,
// one outstanding access at a time, round-robin between the two requesters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wr,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [2:0]        lsu_req_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state
);

  // Handshake rule for all four channels: a transfer happens on a rising edge where
  // valid and ready are both high; ready never depends on anything but state and valids.

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic              req_wr;
  logic [CNT_W-1:0]  count;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  logic [1:0] grant;
  logic       in_idle;
  logic       accept;
  logic       resp_done;

  rr_arb2 u_rr_arb2 (
    .valid      ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign in_idle       = (state == IDLE);
  assign accept        = in_idle && (grant != 2'b00);
  assign ifu_req_ready = in_idle && grant[OWN_IFU];
  assign lsu_req_ready = in_idle && grant[OWN_LSU];

  assign ifu_resp_valid = resp_valid && (owner == OWN_IFU);
  assign lsu_resp_valid = resp_valid && (owner == OWN_LSU);
  assign ifu_resp_data  = ifu_resp_valid ? resp_data : '0;
  assign lsu_resp_data  = lsu_resp_valid ? resp_data : '0;
  assign resp_done      = (ifu_resp_valid && ifu_resp_ready) ||
                          (lsu_resp_valid && lsu_resp_ready);

  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= OWN_LSU;
      owner      <= OWN_IFU;
      req_wr     <= 1'b0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // mem_* are loaded here so the strobe is registered in the ACCESS cycle.
            owner      <= grant[OWN_LSU];
            last_grant <= grant[OWN_LSU];
            mem_en     <= 1'b1;
            if (grant[OWN_LSU]) begin
              req_wr    <= lsu_req_wr;
              mem_wr    <= lsu_req_wr;
              mem_addr  <= lsu_req_addr;
              mem_wdata <= lsu_req_wdata;
              mem_wmask <= lsu_req_wmask;
            end else begin
              req_wr    <= 1'b0;
              mem_wr    <= 1'b0;
              mem_addr  <= ifu_req_addr;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wmask <= '0;
          count     <= CNT_W'(MEM_LAT);
          state     <= WAIT;
        end
        WAIT: begin
          if (count == CNT_W'(1)) begin
            resp_data  <= req_wr ? '0 : mem_rdata;
            resp_valid <= 1'b1;
            count      <= '0;
            state      <= RESP;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_done) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=1 instance for function, a MEM_LAT=3 instance for latency.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // MEM_LAT=1 instance
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [AW-1:0] ifu_req_addr;
  logic [DW-1:0] ifu_resp_data;
  logic          lsu_req_valid, lsu_req_ready, lsu_req_wr, lsu_resp_valid, lsu_resp_ready;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata, lsu_resp_data;
  logic [2:0]    lsu_req_wmask;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    mem_wmask;
  state_t        dbg_state;

  // MEM_LAT=3 instance
  logic          b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_ready;
  logic [AW-1:0] b_ifu_req_addr;
  logic [DW-1:0] b_ifu_resp_data;
  logic          b_lsu_req_valid, b_lsu_req_ready, b_lsu_req_wr, b_lsu_resp_valid, b_lsu_resp_ready;
  logic [AW-1:0] b_lsu_req_addr;
  logic [DW-1:0] b_lsu_req_wdata, b_lsu_resp_data;
  logic [2:0]    b_lsu_req_wmask;
  logic          b_mem_en, b_mem_wr;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;
  logic [2:0]    b_mem_wmask;
  state_t        b_dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wr(lsu_req_wr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_req_addr(b_ifu_req_addr),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(b_ifu_resp_ready), .ifu_resp_data(b_ifu_resp_data),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_req_addr(b_lsu_req_addr),
    .lsu_req_wr(b_lsu_req_wr), .lsu_req_wdata(b_lsu_req_wdata), .lsu_req_wmask(b_lsu_req_wmask),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(b_lsu_resp_ready), .lsu_resp_data(b_lsu_resp_data),
    .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
  );

  // Memory model: word = addr ^ 0x8000_0413, presented exactly MEM_LAT cycles after mem_en, 0 otherwise.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];
  always @(posedge clock) begin
    pipe1    <= mem_en ? mem_word(mem_addr) : '0;
    pipe3[0] <= b_mem_en ? mem_word(b_mem_addr) : '0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata   = pipe1;
  assign b_mem_rdata = pipe3[2];

  // Scoreboard
  int n_total = 0;
  int n_bad   = 0;
  int en_count = 0;
  int n_resp = 0;
  logic mon_on = 1'b0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mem_en) en_count++;
    if (mon_on) begin
      if (mem_en) begin
        if (exp_q.size() == 0) chk("rr_extra_mem_en", 1, 0);
        else chk("rr_mem_addr", mem_addr, exp_q.pop_front());
      end
      if (ifu_resp_valid && ifu_resp_ready) begin
        chk("rr_ifu_data", ifu_resp_data, mem_word(32'h1000));
        n_resp++;
      end
      if (lsu_resp_valid && lsu_resp_ready) begin
        chk("rr_lsu_data", lsu_resp_data, mem_word(32'h2000));
        n_resp++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [1:0] gexp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  int en_base;
  int acc;
  int lat;

  initial begin
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wr = 0; lsu_req_wdata = '0;
    lsu_req_wmask = '0; lsu_resp_ready = 0;
    b_ifu_req_valid = 0; b_ifu_req_addr = '0; b_ifu_resp_ready = 0;
    b_lsu_req_valid = 0; b_lsu_req_addr = '0; b_lsu_req_wr = 0; b_lsu_req_wdata = '0;
    b_lsu_req_wmask = '0; b_lsu_resp_ready = 0;

    // Reset state
    tick(); tick();
    chk("rst_state", dbg_state, IDLE);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst_ready_idle", {lsu_req_ready, ifu_req_ready}, 2'b00);
    reset = 0;
    tick();

    // IFU fetch, MEM_LAT=1
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; #1;
    chk("f_ifu_ready", ifu_req_ready, 1);
    chk("f_lsu_ready", lsu_req_ready, 0);
    tick(); ifu_req_valid = 0; #1;
    chk("f_mem_en_t1", mem_en, 1);
    chk("f_mem_wr", mem_wr, 0);
    chk("f_mem_addr", mem_addr, 32'h8000_0000);
    chk("f_ready_busy", ifu_req_ready, 0);
    tick();
    chk("f_mem_en_t2", mem_en, 0);
    chk("f_mem_addr_t2", mem_addr, 0);
    chk("f_resp_t2", ifu_resp_valid, 0);
    tick();
    chk("f_resp_t3", ifu_resp_valid, 1);
    chk("f_data_t3", ifu_resp_data, 32'h0000_0413);
    chk("f_lsu_resp_t3", lsu_resp_valid, 0);
    ifu_resp_ready = 1; tick(); ifu_resp_ready = 0;
    chk("f_resp_done", ifu_resp_valid, 0);
    chk("f_state_idle", dbg_state, IDLE);

    // LSU store
    en_base = en_count;
    lsu_req_valid = 1; lsu_req_wr = 1; lsu_req_addr = 32'h8000_0100;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 3'b010; #1;
    chk("s_lsu_ready", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; lsu_req_wr = 0; lsu_req_wdata = '0; lsu_req_wmask = '0; #1;
    chk("s_mem_en", mem_en, 1);
    chk("s_mem_wr", mem_wr, 1);
    chk("s_mem_addr", mem_addr, 32'h8000_0100);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_mem_wmask", mem_wmask, 3'b010);
    tick(); tick();
    chk("s_resp_valid", lsu_resp_valid, 1);
    chk("s_resp_data", lsu_resp_data, 0);
    chk("s_ifu_resp", ifu_resp_valid, 0);
    lsu_resp_ready = 1; tick(); lsu_resp_ready = 0;
    chk("s_en_count", en_count - en_base, 1);

    // Both valid: round-robin IFU, LSU, IFU, LSU
    en_base = en_count; n_resp = 0;
    exp_q = {32'h1000, 32'h2000, 32'h1000, 32'h2000};
    mon_on = 1;
    ifu_req_addr = 32'h1000; lsu_req_addr = 32'h2000; lsu_req_wr = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    ifu_req_valid = 1; lsu_req_valid = 1; #1;
    acc = 0;
    for (int c = 0; c < 60 && acc < 4; c++) begin
      if (ifu_req_ready || lsu_req_ready) begin
        chk("rr_grant", {lsu_req_ready, ifu_req_ready}, gexp[acc]);
        acc++;
      end
      tick();
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    chk("rr_accepts", acc, 4);
    for (int c = 0; c < 30 && n_resp < 4; c++) tick();
    tick();
    chk("rr_resp_count", n_resp, 4);
    chk("rr_en_count", en_count - en_base, 4);
    chk("rr_q_empty", exp_q.size(), 0);
    mon_on = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
    tick();

    // Response back-pressure: 5 stalled cycles in RESP
    en_base = en_count;
    ifu_req_valid = 1; ifu_req_addr = 32'h3000; #1;
    tick(); ifu_req_valid = 0;
    tick(); tick();
    ifu_req_valid = 1; lsu_req_valid = 1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", ifu_resp_valid, 1);
      chk("bp_resp_data", ifu_resp_data, mem_word(32'h3000));
      chk("bp_req_ready", {lsu_req_ready, ifu_req_ready}, 2'b00);
      chk("bp_mem_en", mem_en, 0);
      tick();
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    ifu_resp_ready = 1; tick(); ifu_resp_ready = 0;
    chk("bp_done", ifu_resp_valid, 0);
    chk("bp_en_count", en_count - en_base, 1);

    // Reset while in WAIT
    lsu_req_valid = 1; lsu_req_addr = 32'h4000; lsu_req_wr = 0; #1;
    tick(); lsu_req_valid = 0;
    tick();
    chk("rw_in_wait", dbg_state, WAIT);
    reset = 1;
    tick(); reset = 0;
    chk("rw_state", dbg_state, IDLE);
    chk("rw_mem_en", mem_en, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_resp", {lsu_resp_valid, ifu_resp_valid}, 2'b00);
    chk("rw_resp_data", lsu_resp_data, 0);
    tick(); tick(); tick();
    chk("rw_no_late_resp", lsu_resp_valid, 0);
    chk("rw_still_idle", dbg_state, IDLE);
    // Tie after reset goes to IFU
    ifu_req_valid = 1; ifu_req_addr = 32'h5000; lsu_req_valid = 1; #1;
    chk("rw_tie_grant", {lsu_req_ready, ifu_req_ready}, 2'b01);
    tick(); ifu_req_valid = 0; lsu_req_valid = 0;
    tick(); tick();
    chk("rw_new_resp", ifu_resp_valid, 1);
    chk("rw_new_data", ifu_resp_data, mem_word(32'h5000));
    ifu_resp_ready = 1; tick(); ifu_resp_ready = 0;

    // MEM_LAT=3 instance: resp_valid 5 cycles after handshake
    b_ifu_req_valid = 1; b_ifu_req_addr = 32'h6000; #1;
    chk("l3_ready", b_ifu_req_ready, 1);
    tick(); b_ifu_req_valid = 0;
    lat = 1;
    for (int c = 0; c < 20 && !b_ifu_resp_valid; c++) begin
      tick();
      lat++;
    end
    chk("l3_latency", lat, 5);
    chk("l3_data", b_ifu_resp_data, mem_word(32'h6000));
    b_ifu_resp_ready = 1; tick(); b_ifu_resp_ready = 0;
    chk("l3_done", b_ifu_resp_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
